bcd_updown_counter: RTL

Parametrised multi-digit BCD up/down counter: the next generation of the single-digit decimal counter. It supports a configurable digit count, a configurable maximum for the most significant digit, up and down counting, and wrap or saturate mode. It also provides a sticky overflow flag and sanitises default-value loads. It sits in the display/timekeeping datapath, driving the 7-segment decoders and feeding its carry and borrow into the next counter stage.

---
 rtl/bcd_updown_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with wrap or saturate limits.
// Carry/borrow are combinational so they can enable the next stage.
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int TOP_MAX  = 9,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  ld_def,
    input  logic [4*DIGITS-1:0]   def_value,
    output logic [4*DIGITS-1:0]   value,
    output logic                  carry,
    output logic                  borrow,
    output logic                  ovf
);

    localparam logic [3:0] TOP = 4'(TOP_MAX);

    function automatic logic [3:0] digit_max(input int i);
        return (i == DIGITS - 1) ? TOP : 4'd9;
    endfunction

    logic [4*DIGITS-1:0] def_clean;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] next_value;
    logic [DIGITS:0]     lo_max;
    logic [DIGITS:0]     lo_zero;
    logic [3:0]          san_d;
    logic [3:0]          cur_d;
    logic                at_max;
    logic                at_zero;
    logic                limit_hit;

    // Each digit is clamped on its own, so one bad nibble never
    // disturbs its neighbours.
    always_comb begin
        def_clean = '0;
        san_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            san_d = def_value[4*i +: 4];
            if (san_d > digit_max(i)) begin
                san_d = digit_max(i);
            end
            def_clean[4*i +: 4] = san_d;
        end
    end

    // lo_max[i] / lo_zero[i]: every digit below i sits at its limit.
    always_comb begin
        lo_max     = '0;
        lo_zero    = '0;
        lo_max[0]  = 1'b1;
        lo_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            lo_max[i+1]  = lo_max[i] &
                           (value[4*i +: 4] == digit_max(i));
            lo_zero[i+1] = lo_zero[i] &
                           (value[4*i +: 4] == 4'd0);
        end
    end

    assign at_max  = lo_max[DIGITS];
    assign at_zero = lo_zero[DIGITS];

    always_comb begin
        stepped = value;
        cur_d   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_d = value[4*i +: 4];
            if (dir) begin
                if (lo_max[i]) begin
                    stepped[4*i +: 4] =
                        (cur_d == digit_max(i)) ? 4'd0 : cur_d + 4'd1;
                end
            end else begin
                if (lo_zero[i]) begin
                    stepped[4*i +: 4] =
                        (cur_d == 4'd0) ? digit_max(i) : cur_d - 4'd1;
                end
            end
        end
    end

    assign carry     = en & dir & at_max & ~ld_def;
    assign borrow    = en & ~dir & at_zero & ~ld_def;
    assign limit_hit = carry | borrow;

    always_comb begin
        next_value = stepped;
        if (SATURATE && limit_hit) begin
            next_value = value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= def_clean;
            ovf   <= 1'b0;
        end else if (ld_def) begin
            value <= def_clean;
            ovf   <= 1'b0;
        end else if (en) begin
            value <= next_value;
            if (limit_hit) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
